// File: rtl/linreg_pkg.sv
// Shared types and constants for the linear-regression result display.
// Holds the display FSM state type, the digit divider state type, the blank
// digit code, the displayed-value indices and the decimal digit limits.
package linreg_pkg;

  localparam int unsigned DIGIT_W  = 4;
  localparam int unsigned SEL_W    = 2;
  localparam int unsigned DIV_BASE = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DIV  = 2'd2,
    ST_SHOW = 2'd3
  } disp_state_t;

  typedef enum logic {
    DV_IDLE = 1'b0,
    DV_RUN  = 1'b1
  } div_state_t;

  localparam logic [DIGIT_W-1:0] BLANK_DIGIT = 4'hF;
  localparam logic [DIGIT_W-1:0] MAX_DIGIT   = 4'd9;

  localparam logic [SEL_W-1:0] SEL_B     = 2'd0;
  localparam logic [SEL_W-1:0] SEL_SLOPE = 2'd1;
  localparam logic [SEL_W-1:0] SEL_DET   = 2'd2;

endpackage

// File: rtl/linreg_result_display_bcd2_iter_div.sv
// bcd2_iter_div: converts one signed value to sign + two BCD digits by
// repeated subtraction of ten, one compare per clock.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   start         one-cycle request; samples value and blank
//   blank         show blank digits instead of converting the value
//   value [W]     signed value to convert
//   ready         one-cycle pulse when tens/ones/neg/ovf are final
//   tens, ones    BCD digits (BLANK_DIGIT when blanked, 9/9 on overflow)
//   neg           value was negative
//   ovf           |value| > 99
module bcd2_iter_div
  import linreg_pkg::*;
#(
  parameter int unsigned W = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               blank,
  input  logic [W-1:0]       value,
  output logic               ready,
  output logic [DIGIT_W-1:0] tens,
  output logic [DIGIT_W-1:0] ones,
  output logic               neg,
  output logic               ovf
);

  // One extra bit so the magnitude of the most negative value fits.
  localparam int unsigned      REM_W = W + 1;
  localparam logic [REM_W-1:0] TEN   = REM_W'(DIV_BASE);

  div_state_t         state_q, state_d;
  logic [REM_W-1:0]   rem_q, rem_d;
  logic [DIGIT_W-1:0] tens_q, tens_d;
  logic [DIGIT_W-1:0] ones_q, ones_d;
  logic               neg_q, neg_d;
  logic               ovf_q, ovf_d;
  logic               ready_q, ready_d;

  logic [REM_W-1:0]   value_ext_c;
  logic [REM_W-1:0]   value_abs_c;

  // Sign-extended magnitude of the incoming value.
  assign value_ext_c = {value[W-1], value};
  assign value_abs_c = value[W-1] ? (~value_ext_c + REM_W'(1)) : value_ext_c;

  // Load on start, then subtract ten per cycle until below ten or tens saturates.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    neg_d   = neg_q;
    ovf_d   = ovf_q;
    ready_d = 1'b0;
    case (state_q)
      DV_IDLE: begin
        if (start) begin
          ovf_d = 1'b0;
          if (blank) begin
            tens_d  = BLANK_DIGIT;
            ones_d  = BLANK_DIGIT;
            neg_d   = 1'b0;
            ready_d = 1'b1;
          end else begin
            neg_d   = value[W-1];
            rem_d   = value_abs_c;
            tens_d  = '0;
            ones_d  = '0;
            state_d = DV_RUN;
          end
        end
      end
      DV_RUN: begin
        if (rem_q >= TEN) begin
          if (tens_q < MAX_DIGIT) begin
            rem_d  = rem_q - TEN;
            tens_d = tens_q + DIGIT_W'(1);
          end else begin
            ovf_d   = 1'b1;
            tens_d  = MAX_DIGIT;
            ones_d  = MAX_DIGIT;
            ready_d = 1'b1;
            state_d = DV_IDLE;
          end
        end else begin
          ones_d  = rem_q[DIGIT_W-1:0];
          ready_d = 1'b1;
          state_d = DV_IDLE;
        end
      end
      default: state_d = DV_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DV_IDLE;
      rem_q   <= '0;
      tens_q  <= '0;
      ones_q  <= '0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      neg_q   <= neg_d;
      ovf_q   <= ovf_d;
      ready_q <= ready_d;
    end
  end

  assign ready = ready_q;
  assign tens  = tens_q;
  assign ones  = ones_q;
  assign neg   = neg_q;
  assign ovf   = ovf_q;

endmodule

// File: rtl/linreg_result_display.sv
// linreg_result_display: snapshots the regression result on start and steps
// through its values (b, slope[, det]) as sign + two BCD digits, advancing
// on each enter pulse.
// Build option: LINREG_DISPLAY_DET_EN adds det as a third displayed value.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start           one-cycle pulse, snapshots C_out_iny/det/error_det
//   C_out_iny       packed {slope, b}
//   det             signed determinant
//   error_det       singular-matrix flag
//   enter           one-cycle pulse, acknowledges the shown value
//   sel             index of shown value (0=b, 1=slope, 2=det)
//   tens, ones      BCD digits, 4'hF = blank
//   neg, ovf, err   sign, saturation, snapshot error flag
//   valid, busy     digits displayable, sequence in progress
//   done            one-cycle pulse after the last value is acknowledged
module linreg_result_display
  import linreg_pkg::*;
#(
  parameter int unsigned RESULT_WIDTH = 14
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [2*RESULT_WIDTH-1:0] C_out_iny,
  input  logic [RESULT_WIDTH-1:0]   det,
  input  logic                      error_det,
  input  logic                      enter,
  output logic [SEL_W-1:0]          sel,
  output logic [DIGIT_W-1:0]        tens,
  output logic [DIGIT_W-1:0]        ones,
  output logic                      neg,
  output logic                      ovf,
  output logic                      err,
  output logic                      valid,
  output logic                      busy,
  output logic                      done
);

  localparam int unsigned RW = RESULT_WIDTH;

`ifdef LINREG_DISPLAY_DET_EN
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_DET;
`else
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_SLOPE;
`endif

  disp_state_t       state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [2*RW-1:0]   c_q, c_d;
  logic              err_q, err_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              div_start_c;
  logic              div_blank_c;
  logic              div_ready;
  logic [RW-1:0]     cur_value_c;

`ifdef LINREG_DISPLAY_DET_EN
  logic [RW-1:0]     det_q, det_d;
`else
  logic              unused_det_c;
  assign unused_det_c = ^det;
`endif

  // Value currently selected for display.
  always_comb begin
    cur_value_c = c_q[RW-1:0];
    case (sel_q)
      SEL_SLOPE: cur_value_c = c_q[2*RW-1:RW];
`ifdef LINREG_DISPLAY_DET_EN
      SEL_DET:   cur_value_c = det_q;
`endif
      default: ;
    endcase
  end

  // A singular matrix makes b and slope meaningless; det is still shown.
  assign div_blank_c = err_q && (sel_q != SEL_DET);

  // Sequencing FSM: snapshot, convert each value, wait for enter.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    c_d         = c_q;
    err_d       = err_q;
    valid_d     = valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    div_start_c = 1'b0;
`ifdef LINREG_DISPLAY_DET_EN
    det_d       = det_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          c_d     = C_out_iny;
          err_d   = error_det;
`ifdef LINREG_DISPLAY_DET_EN
          det_d   = det;
`endif
          sel_d   = SEL_B;
          busy_d  = 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        div_start_c = 1'b1;
        state_d     = ST_DIV;
      end
      ST_DIV: begin
        if (div_ready) begin
          valid_d = 1'b1;
          state_d = ST_SHOW;
        end
      end
      ST_SHOW: begin
        if (enter) begin
          valid_d = 1'b0;
          if (sel_q == LAST_SEL) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            sel_d   = sel_q + SEL_W'(1);
            state_d = ST_LOAD;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      c_q     <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef LINREG_DISPLAY_DET_EN
      det_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      c_q     <= c_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef LINREG_DISPLAY_DET_EN
      det_q   <= det_d;
`endif
    end
  end

  bcd2_iter_div #(
    .W (RW)
  ) u_div (
    .clk   (clk),
    .rst   (rst),
    .start (div_start_c),
    .blank (div_blank_c),
    .value (cur_value_c),
    .ready (div_ready),
    .tens  (tens),
    .ones  (ones),
    .neg   (neg),
    .ovf   (ovf)
  );

  assign sel   = sel_q;
  assign err   = err_q;
  assign valid = valid_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule
